// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter, its reset value and update rule.
// Reused by the gshare, meta and local predictors.
package bp_pkg;

  typedef logic [1:0] sat_cnt_t;

  localparam sat_cnt_t CNT_INIT = 2'b01;

  function automatic sat_cnt_t sat_cnt_update(sat_cnt_t c, logic taken);
    sat_cnt_t r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + 2'd1;
    end else begin
      if (c != 2'b00) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/global_history_reg.sv
// Global history register for the gshare predictor.
// GLOBAL_PRED_SPEC_HIST_EN selects speculative IF-side history with EX mispredict restore.
module global_history_reg #(
  parameter int H = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         is_branch_if,
  input  logic         stall_if,
  input  logic         predict_taken_if,
  input  logic         is_branch_ex,
  input  logic         cmp_out_ex,
  input  logic [H-1:0] ghr_ex,
  input  logic         predict_taken_ex,
  output logic [H-1:0] ghr
);

  logic [H-1:0] ghr_q;
  logic [H-1:0] ghr_d;
  logic [H:0]   restore_w;

  // Shift via an H+1 wide concat so H = 1 needs no special case.
  assign restore_w = {ghr_ex, cmp_out_ex};

`ifdef GLOBAL_PRED_SPEC_HIST_EN
  logic [H:0] spec_w;
  logic       mispredict;

  assign spec_w     = {ghr_q, predict_taken_if};
  assign mispredict = is_branch_ex && (predict_taken_ex != cmp_out_ex);

  always_comb begin
    ghr_d = ghr_q;
    if (mispredict)
      ghr_d = restore_w[H-1:0];
    else if (is_branch_if && !stall_if)
      ghr_d = spec_w[H-1:0];
  end

  logic unused_hi;
  assign unused_hi = restore_w[H] ^ spec_w[H];
`else
  always_comb begin
    ghr_d = ghr_q;
    if (is_branch_ex)
      ghr_d = restore_w[H-1:0];
  end

  logic unused_in;
  assign unused_in = ^{is_branch_if, stall_if, predict_taken_if, predict_taken_ex, restore_w[H]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      ghr_q <= '0;
    else
      ghr_q <= ghr_d;
  end

  assign ghr = ghr_q;

endmodule

// File: rtl/global_predictor.sv
// Gshare direction predictor: 2-bit counters indexed by PC[n+1:2] XOR global history.
// Optional speculative history via GLOBAL_PRED_SPEC_HIST_EN (see global_history_reg).
module global_predictor
  import bp_pkg::*;
#(
  parameter int N = 128,
  parameter int H = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  pc_if,
  input  logic         is_branch_if,
  input  logic         stall_if,
  output logic         glob_predict_taken_if,
  output logic [H-1:0] ghr_if,
  input  logic         is_branch_ex,
  input  logic         cmp_out_ex,
  input  logic [31:0]  pc_ex,
  input  logic [H-1:0] ghr_ex,
  input  logic         glob_predict_taken_ex
);

  localparam int IDX_W = $clog2(N);

  sat_cnt_t         cnt [N];
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx;

  assign r_idx = pc_if[IDX_W+1:2] ^ IDX_W'(ghr_if);
  assign w_idx = pc_ex[IDX_W+1:2] ^ IDX_W'(ghr_ex);

  // Read is the registered value: a same-cycle write is not bypassed.
  assign glob_predict_taken_if = cnt[r_idx][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++)
        cnt[i] <= CNT_INIT;
    end else if (is_branch_ex) begin
      cnt[w_idx] <= sat_cnt_update(cnt[w_idx], cmp_out_ex);
    end
  end

  global_history_reg #(.H(H)) u_ghr (
    .clk              (clk),
    .rst_n            (rst_n),
    .is_branch_if     (is_branch_if),
    .stall_if         (stall_if),
    .predict_taken_if (glob_predict_taken_if),
    .is_branch_ex     (is_branch_ex),
    .cmp_out_ex       (cmp_out_ex),
    .ghr_ex           (ghr_ex),
    .predict_taken_ex (glob_predict_taken_ex),
    .ghr              (ghr_if)
  );

  logic unused_pc;
  assign unused_pc = ^{pc_if[31:IDX_W+2], pc_if[1:0], pc_ex[31:IDX_W+2], pc_ex[1:0]};

endmodule

// File: tb/tb_global_predictor.sv
// Directed self-checking bench for global_predictor (N = 128, H = 7).
// Builds with or without GLOBAL_PRED_SPEC_HIST_EN; history expectations follow the build.
module tb_global_predictor;

`ifdef GLOBAL_PRED_SPEC_HIST_EN
  localparam bit SPEC_BUILD = 1'b1;
`else
  localparam bit SPEC_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        is_branch_if;
  logic        stall_if;
  logic        glob_predict_taken_if;
  logic [6:0]  ghr_if;
  logic        is_branch_ex;
  logic        cmp_out_ex;
  logic [31:0] pc_ex;
  logic [6:0]  ghr_ex;
  logic        glob_predict_taken_ex;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [6:0]  exp_ghr;

  global_predictor #(.N(128), .H(7)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .pc_if                 (pc_if),
    .is_branch_if          (is_branch_if),
    .stall_if              (stall_if),
    .glob_predict_taken_if (glob_predict_taken_if),
    .ghr_if                (ghr_if),
    .is_branch_ex          (is_branch_ex),
    .cmp_out_ex            (cmp_out_ex),
    .pc_ex                 (pc_ex),
    .ghr_ex                (ghr_ex),
    .glob_predict_taken_ex (glob_predict_taken_ex)
  );

  always #5 clk = ~clk;

  // PC whose read index lands on table entry idx given history g.
  function automatic logic [31:0] pc_for(input logic [6:0] idx, input logic [6:0] g);
    return {23'd0, idx ^ g, 2'b00};
  endfunction

  // Called at posedge+1; returns at the next posedge+1 with EX deasserted.
  task automatic train(input logic [31:0] pc, input logic [6:0] g, input logic taken,
                       input logic pred);
    pc_ex = pc; ghr_ex = g; cmp_out_ex = taken; glob_predict_taken_ex = pred;
    is_branch_ex = 1'b1;
    @(posedge clk); #1;
    is_branch_ex = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ghr = '0;
  endtask

  task automatic test_reset();
    do_reset();
    pc_if = 32'h100;
    #1;
    n_tests++;
    if (glob_predict_taken_if !== 1'b0) begin
      n_fail++; $display("FAIL reset_pred got=%b exp=0", glob_predict_taken_if);
    end
    n_tests++;
    if (ghr_if !== 7'h00) begin
      n_fail++; $display("FAIL reset_ghr got=%h exp=00", ghr_if);
    end
  endtask

  // Entry 0x40 trained with ghr_ex = 0; correct prediction flag keeps spec-build GHR at 0.
  task automatic test_saturation();
    logic [7:0] outcome;
    logic [7:0] exp_pred;
    outcome  = 8'b1000_0111;  // bit 0 first: T T T N N N N T
    exp_pred = 8'b0000_1111;  // 10 11 11 10 01 00 00 01
    for (int i = 0; i < 8; i++) begin
      train(32'h100, 7'h00, outcome[i], outcome[i]);
      exp_ghr = SPEC_BUILD ? 7'h00 : {6'd0, outcome[i]};
      pc_if = pc_for(7'h40, exp_ghr);
      #1;
      n_tests++;
      if (glob_predict_taken_if !== exp_pred[i]) begin
        n_fail++; $display("FAIL sat_pred step=%0d got=%b exp=%b", i, glob_predict_taken_if, exp_pred[i]);
      end
      n_tests++;
      if (ghr_if !== exp_ghr) begin
        n_fail++; $display("FAIL sat_ghr step=%0d got=%h exp=%h", i, ghr_if, exp_ghr);
      end
    end
  endtask

`ifndef GLOBAL_PRED_SPEC_HIST_EN
  task automatic test_history();
    logic [2:0] seq;
    logic [6:0] exp_seq [3];
    seq = 3'b101;
    exp_seq[0] = 7'h01; exp_seq[1] = 7'h02; exp_seq[2] = 7'h05;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      train(32'h200, exp_ghr, seq[2-i], 1'b0);
      exp_ghr = exp_seq[i];
      #1;
      n_tests++;
      if (ghr_if !== exp_ghr) begin
        n_fail++; $display("FAIL hist_ghr step=%0d got=%h exp=%h", i, ghr_if, exp_ghr);
      end
    end
  endtask

  task automatic test_same_cycle();
    pc_if = 32'h100;
    pc_ex = 32'h100; ghr_ex = 7'h05; cmp_out_ex = 1'b1; glob_predict_taken_ex = 1'b0;
    is_branch_ex = 1'b1;
    #1;
    n_tests++;
    if (glob_predict_taken_if !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_old got=%b exp=0", glob_predict_taken_if);
    end
    @(posedge clk); #1;
    is_branch_ex = 1'b0;
    exp_ghr = 7'h0B;
    pc_if = pc_for(7'h45, exp_ghr);
    #1;
    n_tests++;
    if (glob_predict_taken_if !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_new got=%b exp=1", glob_predict_taken_if);
    end
    n_tests++;
    if (ghr_if !== exp_ghr) begin
      n_fail++; $display("FAIL same_cycle_ghr got=%h exp=%h", ghr_if, exp_ghr);
    end
  endtask
`else
  task automatic test_spec_history();
    do_reset();
    train(32'h100, 7'h00, 1'b1, 1'b1);
    is_branch_if = 1'b1; stall_if = 1'b0;
    pc_if = 32'h100;
    #1;
    n_tests++;
    if (glob_predict_taken_if !== 1'b1) begin
      n_fail++; $display("FAIL spec_pred got=%b exp=1", glob_predict_taken_if);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ghr_if !== 7'h01) begin
      n_fail++; $display("FAIL spec_shift got=%h exp=01", ghr_if);
    end
    stall_if = 1'b1;
    pc_if = pc_for(7'h40, 7'h01);
    @(posedge clk); #1;
    n_tests++;
    if (ghr_if !== 7'h01) begin
      n_fail++; $display("FAIL spec_stall got=%h exp=01", ghr_if);
    end
    stall_if = 1'b0;
    pc_ex = 32'h200; ghr_ex = 7'h0A; cmp_out_ex = 1'b0; glob_predict_taken_ex = 1'b1;
    is_branch_ex = 1'b1;
    @(posedge clk); #1;
    is_branch_ex = 1'b0; is_branch_if = 1'b0;
    n_tests++;
    if (ghr_if !== 7'h14) begin
      n_fail++; $display("FAIL spec_restore got=%h exp=14", ghr_if);
    end
    exp_ghr = 7'h14;
  endtask
`endif

  task automatic test_reset_override();
    // Bring entry 0x45 to 10 before the override.
    do_reset();
    train(32'h100, 7'h05, 1'b1, 1'b1);
    exp_ghr = SPEC_BUILD ? 7'h00 : 7'h0B;
    pc_if = pc_for(7'h45, exp_ghr);
    #1;
    n_tests++;
    if (glob_predict_taken_if !== 1'b1) begin
      n_fail++; $display("FAIL rst_ovr_pre got=%b exp=1", glob_predict_taken_if);
    end
    rst_n = 1'b0;
    pc_ex = 32'h100; ghr_ex = 7'h05; cmp_out_ex = 1'b1; glob_predict_taken_ex = 1'b0;
    is_branch_ex = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; is_branch_ex = 1'b0;
    exp_ghr = '0;
    pc_if = pc_for(7'h45, exp_ghr);
    #1;
    n_tests++;
    if (glob_predict_taken_if !== 1'b0) begin
      n_fail++; $display("FAIL rst_ovr_pred got=%b exp=0", glob_predict_taken_if);
    end
    n_tests++;
    if (ghr_if !== 7'h00) begin
      n_fail++; $display("FAIL rst_ovr_ghr got=%h exp=00", ghr_if);
    end
    // One taken step from 01 must reach 10.
    train(32'h114, 7'h00, 1'b1, 1'b1);
    exp_ghr = SPEC_BUILD ? 7'h00 : 7'h01;
    pc_if = pc_for(7'h45, exp_ghr);
    #1;
    n_tests++;
    if (glob_predict_taken_if !== 1'b1) begin
      n_fail++; $display("FAIL rst_ovr_init got=%b exp=1", glob_predict_taken_if);
    end
  endtask

  initial begin
    rst_n = 1'b0; pc_if = '0; is_branch_if = 1'b0; stall_if = 1'b0;
    is_branch_ex = 1'b0; cmp_out_ex = 1'b0; pc_ex = '0; ghr_ex = '0;
    glob_predict_taken_ex = 1'b0; exp_ghr = '0;
    @(posedge clk); #1;
    test_reset();
    test_saturation();
`ifndef GLOBAL_PRED_SPEC_HIST_EN
    test_history();
    test_same_cycle();
`else
    test_spec_history();
`endif
    test_reset_override();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
